gfx_cmd_list_master: RTL and testbench

- Bus initiator that drives the graphics accelerator's register slave from a command list held in memory.
- Fetches 32-bit command words through a read-only memory master port.
- Turns each command into a register write on the gfx register port, or into polling of GFX_STATUS (8'h04) bit GFX_STAT_BUSY.
- Lets software queue register setup plus draw triggers without CPU intervention.

---
 rtl/gfx256_pkg.sv | 38 +++
 rtl/gfx_cmd_list_master.sv | 264 ++++++++++++++++++++++++++
 tb/tb_gfx_cmd_list_master.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx256_pkg.sv
// gfx256_pkg
//   Shared definitions for the gfx256 accelerator slice: register map
//   entries used by bus initiators, command-list opcodes, the command-list
//   master state type and small decode helpers.
package gfx256_pkg;

  // Register map entries consumed by the command-list master
  localparam logic [7:0] GFX_STATUS    = 8'h04;
  localparam int         GFX_STAT_BUSY = 0;

  // Command-list opcodes (word0[31:24])
  localparam logic [7:0] GFX_CMD_NOP       = 8'h00;
  localparam logic [7:0] GFX_CMD_WRITE     = 8'h01;
  localparam logic [7:0] GFX_CMD_WAIT_IDLE = 8'h02;
  localparam logic [7:0] GFX_CMD_END       = 8'hFF;

  // Command-list master states
  typedef enum logic [2:0] {
    GFX_CS_IDLE       = 3'd0,
    GFX_CS_FETCH_CMD  = 3'd1,
    GFX_CS_FETCH_DATA = 3'd2,
    GFX_CS_WRITE      = 3'd3,
    GFX_CS_POLL       = 3'd4,
    GFX_CS_DONE       = 3'd5,
    GFX_CS_ERR        = 3'd6
  } gfx_cmd_state_t;

  // Opcode field of a command word
  function automatic logic [7:0] gfx_cmd_opcode(input logic [31:0] word);
    return word[31:24];
  endfunction

  // Register addresses on the gfx port must be 32-bit aligned
  function automatic logic gfx_reg_aligned(input logic [7:0] adr);
    return (adr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/gfx_cmd_list_master.sv
// gfx_cmd_list_master
//   Walks a command list in memory and replays it onto the gfx register
//   port: WRITE commands become register writes, WAIT_IDLE polls the
//   STATUS register until the busy bit clears (bounded by POLL_LIMIT).
//   Both ports use a single-beat handshake with strobes held until ack and
//   dropped the cycle after it.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i, abort_i        list start pulse, abort request
//   list_base_i, list_len_i list byte address and maximum word count
//   busy_o, done_o, err_o   list running, completion pulse, sticky error
//   mem_*                   read-only memory master port
//   reg_*                   gfx register-port master
module gfx_cmd_list_master
  import gfx256_pkg::*;
#(
  parameter int POLL_LIMIT = 65535,
  parameter int LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      list_base_i,
  input  logic [LEN_W-1:0] list_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             mem_cyc_o,
  output logic             mem_stb_o,
  output logic [31:0]      mem_adr_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_dat_i,
  output logic             reg_cyc_o,
  output logic             reg_stb_o,
  output logic             reg_we_o,
  output logic [3:0]       reg_sel_o,
  output logic [7:0]       reg_adr_o,
  output logic [31:0]      reg_dat_o,
  input  logic             reg_ack_i,
  input  logic [31:0]      reg_dat_i
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  gfx_cmd_state_t   state_r;
  logic [31:0]      ptr_r;
  logic [LEN_W-1:0] remaining_r;
  logic [7:0]       cmd_adr_r;
  logic [31:0]      wr_dat_r;
  logic [PCW-1:0]   poll_cnt_r;
  logic             abort_req_r;

  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             mem_req_r;
  logic [31:0]      mem_adr_r;
  logic             reg_req_r;
  logic             reg_we_r;
  logic [3:0]       reg_sel_r;
  logic [7:0]       reg_adr_r;
  logic [31:0]      reg_dat_r;

  logic             abort_pend_s;
  logic [LEN_W-1:0] rem_dec_s;
  logic             rem_dec_zero_s;
  logic             rem_zero_s;
  logic [PCW-1:0]   poll_nxt_s;
  logic [7:0]       opcode_s;
  logic             status_busy_s;
  logic             unused_status_s;

  // Next-value helpers for counters and decode of the incoming words
  always_comb begin
    abort_pend_s    = abort_req_r | abort_i;
    rem_dec_s       = remaining_r - LEN_W'(1);
    rem_dec_zero_s  = (rem_dec_s == {LEN_W{1'b0}});
    rem_zero_s      = (remaining_r == {LEN_W{1'b0}});
    poll_nxt_s      = poll_cnt_r + PCW'(1);
    opcode_s        = gfx_cmd_opcode(mem_dat_i);
    status_busy_s   = reg_dat_i[GFX_STAT_BUSY];
    // Only the busy bit of STATUS matters here
    unused_status_s = ^reg_dat_i;
  end

  // List sequencer: fetch, decode, register write / status poll, completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= GFX_CS_IDLE;
      ptr_r       <= 32'h0000_0000;
      remaining_r <= {LEN_W{1'b0}};
      cmd_adr_r   <= 8'h00;
      wr_dat_r    <= 32'h0000_0000;
      poll_cnt_r  <= {PCW{1'b0}};
      abort_req_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_adr_r   <= 32'h0000_0000;
      reg_req_r   <= 1'b0;
      reg_we_r    <= 1'b0;
      reg_sel_r   <= 4'hF;
      reg_adr_r   <= 8'h00;
      reg_dat_r   <= 32'h0000_0000;
    end else begin
      done_r    <= 1'b0;
      reg_sel_r <= 4'hF;
      // Abort is remembered until the next point with no beat in flight
      if ((state_r != GFX_CS_IDLE) && abort_i) begin
        abort_req_r <= 1'b1;
      end
      case (state_r)
        GFX_CS_IDLE: begin
          // A start in the same cycle as an abort wins; the abort is dropped
          abort_req_r <= 1'b0;
          if (start_i) begin
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            ptr_r       <= list_base_i;
            remaining_r <= list_len_i;
            poll_cnt_r  <= {PCW{1'b0}};
            state_r     <= (list_len_i == {LEN_W{1'b0}}) ? GFX_CS_DONE : GFX_CS_FETCH_CMD;
          end
        end

        GFX_CS_FETCH_CMD: begin
          if (!mem_req_r) begin
            if (abort_pend_s) begin
              abort_req_r <= 1'b0;
              busy_r      <= 1'b0;
              state_r     <= GFX_CS_IDLE;
            end else begin
              mem_req_r <= 1'b1;
              mem_adr_r <= ptr_r;
            end
          end else if (mem_ack_i) begin
            mem_req_r   <= 1'b0;
            ptr_r       <= ptr_r + 32'd4;
            remaining_r <= rem_dec_s;
            case (opcode_s)
              GFX_CMD_NOP: begin
                state_r <= rem_dec_zero_s ? GFX_CS_DONE : GFX_CS_FETCH_CMD;
              end
              GFX_CMD_WRITE: begin
                // A WRITE whose data word lies beyond the list is malformed
                if (!gfx_reg_aligned(mem_dat_i[7:0]) || rem_dec_zero_s) begin
                  state_r <= GFX_CS_ERR;
                end else begin
                  cmd_adr_r <= mem_dat_i[7:0];
                  state_r   <= GFX_CS_FETCH_DATA;
                end
              end
              GFX_CMD_WAIT_IDLE: state_r <= GFX_CS_POLL;
              GFX_CMD_END:       state_r <= GFX_CS_DONE;
              default:           state_r <= GFX_CS_ERR;
            endcase
          end
        end

        GFX_CS_FETCH_DATA: begin
          if (!mem_req_r) begin
            if (abort_pend_s) begin
              abort_req_r <= 1'b0;
              busy_r      <= 1'b0;
              state_r     <= GFX_CS_IDLE;
            end else begin
              mem_req_r <= 1'b1;
              mem_adr_r <= ptr_r;
            end
          end else if (mem_ack_i) begin
            mem_req_r   <= 1'b0;
            wr_dat_r    <= mem_dat_i;
            ptr_r       <= ptr_r + 32'd4;
            remaining_r <= rem_dec_s;
            state_r     <= GFX_CS_WRITE;
          end
        end

        GFX_CS_WRITE: begin
          if (!reg_req_r) begin
            if (abort_pend_s) begin
              abort_req_r <= 1'b0;
              busy_r      <= 1'b0;
              state_r     <= GFX_CS_IDLE;
            end else begin
              reg_req_r <= 1'b1;
              reg_we_r  <= 1'b1;
              reg_adr_r <= cmd_adr_r;
              reg_dat_r <= wr_dat_r;
            end
          end else if (reg_ack_i) begin
            reg_req_r <= 1'b0;
            reg_we_r  <= 1'b0;
            state_r   <= rem_zero_s ? GFX_CS_DONE : GFX_CS_FETCH_CMD;
          end
        end

        GFX_CS_POLL: begin
          if (!reg_req_r) begin
            if (abort_pend_s) begin
              abort_req_r <= 1'b0;
              busy_r      <= 1'b0;
              state_r     <= GFX_CS_IDLE;
            end else begin
              reg_req_r <= 1'b1;
              reg_we_r  <= 1'b0;
              reg_adr_r <= GFX_STATUS;
              reg_dat_r <= 32'h0000_0000;
            end
          end else if (reg_ack_i) begin
            reg_req_r <= 1'b0;
            if (!status_busy_s) begin
              poll_cnt_r <= {PCW{1'b0}};
              state_r    <= rem_zero_s ? GFX_CS_DONE : GFX_CS_FETCH_CMD;
            end else if (poll_nxt_s == PCW'(POLL_LIMIT)) begin
              poll_cnt_r <= poll_nxt_s;
              state_r    <= GFX_CS_ERR;
            end else begin
              poll_cnt_r <= poll_nxt_s;
            end
          end
        end

        GFX_CS_DONE: begin
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
          abort_req_r <= 1'b0;
          state_r     <= GFX_CS_IDLE;
        end

        GFX_CS_ERR: begin
          err_r       <= 1'b1;
          busy_r      <= 1'b0;
          abort_req_r <= 1'b0;
          state_r     <= GFX_CS_IDLE;
        end

        default: begin
          busy_r    <= 1'b0;
          mem_req_r <= 1'b0;
          reg_req_r <= 1'b0;
          reg_we_r  <= 1'b0;
          state_r   <= GFX_CS_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign err_o     = err_r;
  assign mem_cyc_o = mem_req_r;
  assign mem_stb_o = mem_req_r;
  assign mem_adr_o = mem_adr_r;
  assign reg_cyc_o = reg_req_r;
  assign reg_stb_o = reg_req_r;
  assign reg_we_o  = reg_we_r;
  assign reg_sel_o = reg_sel_r;
  assign reg_adr_o = reg_adr_r;
  assign reg_dat_o = reg_dat_r;

endmodule

// File: tb/tb_gfx_cmd_list_master.sv
// tb_gfx_cmd_list_master
//   Self-checking bench: memory and register-port responders with random
//   ack latency, a command-list interpreter as reference, directed cases
//   plus randomized lists.
module tb_gfx_cmd_list_master;

  localparam int LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, abort_i;
  logic [31:0] list_base_i;
  logic [15:0] list_len_i;
  logic        busy_o, done_o, err_o;
  logic        mem_cyc_o, mem_stb_o, mem_ack_i;
  logic [31:0] mem_adr_o, mem_dat_i;
  logic        reg_cyc_o, reg_stb_o, reg_we_o, reg_ack_i;
  logic [3:0]  reg_sel_o;
  logic [7:0]  reg_adr_o;
  logic [31:0] reg_dat_o, reg_dat_i;

  gfx_cmd_list_master #(.POLL_LIMIT(LIMIT), .LEN_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .list_base_i(list_base_i), .list_len_i(list_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_adr_o(mem_adr_o),
    .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i),
    .reg_cyc_o(reg_cyc_o), .reg_stb_o(reg_stb_o), .reg_we_o(reg_we_o),
    .reg_sel_o(reg_sel_o), .reg_adr_o(reg_adr_o), .reg_dat_o(reg_dat_o),
    .reg_ack_i(reg_ack_i), .reg_dat_i(reg_dat_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] fetch_q[$], exp_fetch_q[$];
  logic [39:0] wr_q[$], exp_wr_q[$];
  int stat_reads, exp_stat;
  int exp_done, exp_err;
  int mem_delay = 0, reg_delay = 0, busy_n = 0, busy_cnt = 0;
  int mem_cnt, reg_cnt;
  logic [31:0] mem_hold;
  logic [40:0] reg_hold;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_0000;
  endfunction

  // Memory responder: ack after mem_delay wait cycles, checks hold and drop
  initial begin
    mem_ack_i = 1'b0; mem_dat_i = 32'h0; mem_cnt = -1;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        mem_ack_i = 1'b0; mem_cnt = -1;
      end else if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        check_val("mem_strobe_drop", {mem_cyc_o, mem_stb_o}, 2'b00);
      end else if (mem_cyc_o && mem_stb_o) begin
        if (mem_cnt < 0) begin
          mem_cnt = mem_delay; mem_hold = mem_adr_o;
        end else begin
          check_val("mem_adr_hold", mem_adr_o, mem_hold);
        end
        if (mem_cnt == 0) begin
          mem_ack_i = 1'b1; mem_dat_i = mem_rd(mem_adr_o);
          fetch_q.push_back(mem_adr_o); mem_cnt = -1;
        end else begin
          mem_cnt--;
        end
      end
    end
  end

  // Register-port responder: logs writes, answers STATUS reads busy_n times busy
  initial begin
    logic [31:0] r;
    logic        bsy;
    reg_ack_i = 1'b0; reg_dat_i = 32'h0; reg_cnt = -1;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        reg_ack_i = 1'b0; reg_cnt = -1;
      end else if (reg_ack_i) begin
        reg_ack_i = 1'b0;
        check_val("reg_strobe_drop", {reg_cyc_o, reg_stb_o}, 2'b00);
      end else if (reg_cyc_o && reg_stb_o) begin
        if (reg_cnt < 0) begin
          reg_cnt = reg_delay; reg_hold = {reg_we_o, reg_adr_o, reg_dat_o};
        end else begin
          check_val("reg_beat_hold", {reg_we_o, reg_adr_o, reg_dat_o}, reg_hold);
        end
        if (reg_cnt == 0) begin
          reg_ack_i = 1'b1; reg_cnt = -1;
          check_val("reg_sel", reg_sel_o, 4'hF);
          if (reg_we_o) begin
            wr_q.push_back({reg_adr_o, reg_dat_o});
          end else begin
            check_val("poll_adr", reg_adr_o, 8'h04);
            stat_reads++;
            bsy = (busy_cnt < busy_n);
            if (bsy) busy_cnt++; else busy_cnt = 0;
            r = $urandom();
            reg_dat_i = {r[31:1], bsy};
          end
        end else begin
          reg_cnt--;
        end
      end
    end
  end

  // Reference: interpret the list word by word
  task automatic model_run(input logic [31:0] base, input int len);
    logic [31:0] a, w, d;
    int rem;
    bit fin;
    exp_fetch_q.delete(); exp_wr_q.delete();
    exp_stat = 0; exp_done = 0; exp_err = 0;
    a = base; rem = len; fin = (len == 0);
    if (fin) exp_done = 1;
    while (!fin) begin
      w = mem_rd(a); exp_fetch_q.push_back(a); a += 32'd4; rem--;
      case (w[31:24])
        8'h00: if (rem == 0) begin exp_done = 1; fin = 1; end
        8'h01: begin
          if (w[1:0] != 2'b00 || rem == 0) begin
            exp_err = 1; fin = 1;
          end else begin
            d = mem_rd(a); exp_fetch_q.push_back(a); a += 32'd4; rem--;
            exp_wr_q.push_back({w[7:0], d});
            if (rem == 0) begin exp_done = 1; fin = 1; end
          end
        end
        8'h02: begin
          if (busy_n >= LIMIT) begin
            exp_stat += LIMIT; exp_err = 1; fin = 1;
          end else begin
            exp_stat += busy_n + 1;
            if (rem == 0) begin exp_done = 1; fin = 1; end
          end
        end
        8'hFF: begin exp_done = 1; fin = 1; end
        default: begin exp_err = 1; fin = 1; end
      endcase
    end
  endtask

  task automatic run_list(input string tag, input logic [31:0] base, input int len,
                          input bit poke, output int done_at);
    int cyc, done_cnt;
    bit timed_out;
    model_run(base, len);
    fetch_q.delete(); wr_q.delete(); stat_reads = 0; busy_cnt = 0;
    @(negedge clk_i);
    list_base_i = base; list_len_i = len[15:0]; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; cyc = 1;
    check_val({tag, "_busy_start"}, busy_o, 1'b1);
    check_val({tag, "_err_cleared"}, err_o, 1'b0);
    done_cnt = 0; done_at = -1; timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (done_o) begin done_cnt++; if (done_at < 0) done_at = cyc; end
      if (!busy_o) begin timed_out = 1'b0; break; end
      // A start while busy must be ignored
      if (poke && cyc == 4) begin start_i = 1'b1; list_base_i = ~base; end
      else start_i = 1'b0;
      @(negedge clk_i); cyc++;
    end
    start_i = 1'b0;
    check_val({tag, "_timeout"}, timed_out, 1'b0);
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
    end
    check_val({tag, "_done_pulses"}, done_cnt, exp_done);
    check_val({tag, "_err"}, err_o, exp_err);
    check_val({tag, "_busy_end"}, busy_o, 1'b0);
    check_val({tag, "_fetch_n"}, fetch_q.size(), exp_fetch_q.size());
    for (int i = 0; i < exp_fetch_q.size() && i < fetch_q.size(); i++)
      check_val({tag, "_fetch_adr"}, fetch_q[i], exp_fetch_q[i]);
    check_val({tag, "_write_n"}, wr_q.size(), exp_wr_q.size());
    for (int i = 0; i < exp_wr_q.size() && i < wr_q.size(); i++)
      check_val({tag, "_write"}, wr_q[i], exp_wr_q[i]);
    check_val({tag, "_status_reads"}, stat_reads, exp_stat);
  endtask

  task automatic gen_list(input logic [31:0] base, input int len);
    logic [31:0] a, r;
    int i, k;
    mem.delete();
    i = 0;
    while (i < len + 2) begin
      a = base + 32'(4 * i);
      r = $urandom();
      k = $urandom_range(0, 19);
      if (k < 5) begin
        mem[a] = {8'h00, r[23:0]}; i++;
      end else if (k < 11) begin
        mem[a] = {8'h01, 16'h0000, r[7:2], (r[10:8] == 3'd0) ? 2'b10 : 2'b00};
        mem[a + 32'd4] = $urandom(); i += 2;
      end else if (k < 16) begin
        mem[a] = 32'h0200_0000; i++;
      end else if (k < 19) begin
        mem[a] = 32'hFF00_0000; i++;
      end else begin
        mem[a] = (r[0]) ? 32'h7E00_0000 : 32'h0300_0000; i++;
      end
    end
  endtask

  initial begin
    int done_at;
    int k;
    bit seen;
    logic [31:0] base;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    list_base_i = 32'h0; list_len_i = 16'h0;
    repeat (3) @(negedge clk_i);
    check_val("reset_ctrl", {busy_o, done_o, err_o, mem_cyc_o, mem_stb_o,
                             reg_cyc_o, reg_stb_o, reg_we_o, reg_sel_o}, {8'h00, 4'hF});
    check_val("reset_adr", {mem_adr_o, reg_adr_o}, 40'h0);
    check_val("reset_dat", reg_dat_o, 32'h0);
    rst_ni = 1'b1;

    // Reference list with three busy STATUS answers
    mem.delete();
    mem[32'h1000] = 32'h0100_0084; mem[32'h1004] = 32'h00FF_00FF;
    mem[32'h1008] = 32'h0200_0000; mem[32'h100C] = 32'hFF00_0000;
    mem[32'h1010] = 32'h7E00_0000;
    busy_n = 3; mem_delay = 1; reg_delay = 2;
    run_list("basic", 32'h1000, 5, 1'b1, done_at);
    check_val("basic_write", (wr_q.size() > 0) ? wr_q[0] : 40'h0, {8'h84, 32'h00FF_00FF});
    check_val("basic_polls", stat_reads, 4);
    check_val("basic_last_fetch", (fetch_q.size() > 0) ? fetch_q[fetch_q.size()-1] : 32'h0, 32'h100C);

    // Empty list
    run_list("len0", 32'h1000, 0, 1'b0, done_at);
    check_val("len0_done_latency", done_at, 2);

    // Unknown opcode, then a fresh start clears the error
    mem.delete();
    mem[32'h3000] = 32'h7E00_0000;
    run_list("badop", 32'h3000, 3, 1'b0, done_at);
    check_val("badop_err_set", err_o, 1'b1);
    run_list("badop_clear", 32'h3000, 0, 1'b0, done_at);

    // STATUS never idles
    mem.delete();
    mem[32'h4000] = 32'h0200_0000; mem[32'h4004] = 32'hFF00_0000;
    busy_n = 1000;
    run_list("stuck", 32'h4000, 2, 1'b0, done_at);
    check_val("stuck_polls", stat_reads, 4);
    busy_n = 0;

    // Abort during a slow data fetch
    mem.delete();
    mem[32'h5000] = 32'h0100_0010; mem[32'h5004] = 32'hCAFE_F00D;
    mem[32'h5008] = 32'hFF00_0000;
    mem_delay = 5; fetch_q.delete(); wr_q.delete();
    @(negedge clk_i);
    list_base_i = 32'h5000; list_len_i = 16'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_stb_o && mem_adr_o == 32'h5004) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    check_val("abort_reach_data", seen, 1'b1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0; k = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_o) k++;
      if (!busy_o) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    repeat (6) begin @(negedge clk_i); if (done_o) k++; end
    check_val("abort_idle", seen, 1'b1);
    check_val("abort_fetches", fetch_q.size(), 2);
    check_val("abort_data_read", (fetch_q.size() > 1) ? fetch_q[1] : 32'h0, 32'h5004);
    check_val("abort_no_write", wr_q.size(), 0);
    check_val("abort_no_done", k, 0);
    check_val("abort_err", err_o, 1'b0);
    check_val("abort_reg_idle", {reg_cyc_o, reg_stb_o}, 2'b00);

    // Reset in the middle of the register write
    mem.delete();
    mem[32'h2000] = 32'h0100_0040; mem[32'h2004] = 32'h1234_5678;
    mem[32'h2008] = 32'h0200_0000; mem[32'h200C] = 32'hFF00_0000;
    mem_delay = 0; reg_delay = 6;
    @(negedge clk_i);
    list_base_i = 32'h2000; list_len_i = 16'd4; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (reg_stb_o && reg_we_o) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    check_val("rst_reach_write", seen, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_val("rst_strobes", {mem_cyc_o, mem_stb_o, reg_cyc_o, reg_stb_o, reg_we_o, busy_o, done_o}, 7'h00);
    check_val("rst_sel", reg_sel_o, 4'hF);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1; reg_delay = 1;
    run_list("rst_rerun", 32'h2000, 4, 1'b0, done_at);

    // Randomized lists
    for (int it = 0; it < 40; it++) begin
      base = $urandom();
      base[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) base = 32'hFFFF_FFF0;
      k = $urandom_range(0, 9);
      gen_list(base, k);
      busy_n    = $urandom_range(0, 5);
      mem_delay = $urandom_range(0, 3);
      reg_delay = $urandom_range(0, 3);
      run_list("rand", base, k, ($urandom_range(0, 1) == 1), done_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
